lc4_div_iter: RTL and testbench
===============================

Name: lc4_div_iter

Overview:
- Iterative unsigned divider that sits directly downstream of the 16-bit carry-lookahead adder in the LC4 ALU.
- It reuses one cla16 instance as a restoring-division subtractor, retiring one quotient bit per clock.
- It serves the DIV/MOD opcodes through a valid/ready start handshake and a valid/ready result handshake.
- It replaces a 16-deep combinational subtractor chain, trading area for multi-cycle latency.

Parameters:
- WIDTH, 16, operand and result width. The cla16 instance is used when WIDTH==16; any other WIDTH uses a generic (WIDTH+1)-bit subtract.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start_valid  input  1  operands presented.
- start_ready  output  1  block can accept operands.
- dividend  input  WIDTH  unsigned dividend, sampled on start handshake.
- divisor  input  WIDTH  unsigned divisor, sampled on start handshake.
- result_valid  output  1  quotient/remainder available.
- result_ready  input  1  consumer takes the result.
- quotient  output  WIDTH  unsigned quotient.
- remainder  output  WIDTH  unsigned remainder.
- busy  output  1  high in RUN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, count=0.
  - start_ready=1, result_valid=0, busy=0.
  - quotient=0, remainder=0.
  - Internal rem/quo/divisor registers are cleared.
  - Reset mid-RUN or mid-DONE aborts the operation; no result is ever produced for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready: latch dvd->quo, dvs->dreg, clear rem and count, go to RUN.
  - start_valid without start_ready is ignored in every other state; operands are not sampled.
- RUN, one iteration per cycle:
  - {rem,quo} shifts left 1.
  - trial = {1'b0,rem_shifted} - {1'b0,dreg}, computed as a+~b with cin=1 in WIDTH+1 bits.
  - No borrow: rem<=trial[WIDTH-1:0], quo[0]<=1.
  - Otherwise rem is kept and quo[0]<=0.
  - count increments; after iteration count==WIDTH-1, go to DONE.
- Latency: result_valid rises on the WIDTH-th rising edge after the accepting edge (16 cycles at default).
- DONE:
  - result_valid=1.
  - quotient/remainder are driven from registers and held stable while result_ready=0, for any number of cycles.
  - On result_valid&&result_ready: go to IDLE. start_ready is high the following cycle; there is no same-cycle accept.
- Divide by zero:
  - LC4 semantics: quotient=0, remainder=0.
  - dreg==0 is flagged at accept, and the DONE outputs are forced to 0 regardless of the iteration data.
- Arithmetic:
  - Unsigned only.
  - Results satisfy dividend == quotient*divisor + remainder, with remainder < divisor for divisor≠0.
- start_ready and result_valid are never simultaneously high.

Optional Feature:
- Macro: LC4_DIV_EARLY_EXIT_EN.
- Defined:
  - At accept, if divisor==0 or dividend<divisor (unsigned), the block skips RUN and goes straight to DONE.
  - The DONE outputs are then quotient=0 and remainder=dividend (or 0/0 when divisor==0).
  - result_valid rises on the 1st edge after accept.
- Undefined:
  - Every operation takes exactly WIDTH RUN cycles.
  - The outputs are identical to the defined case; only latency differs.

Test Plan:
- Reset then dividend=100, divisor=7 -> result_valid exactly 16 edges after accept; quotient=14, remainder=2; start_ready=0 and busy=1 throughout RUN.
- dividend=16'hFFFF, divisor=1 -> quotient=16'hFFFF, remainder=0; then dividend=16'hFFFF, divisor=16'hFFFF -> quotient=1, remainder=0.
- dividend=1234, divisor=0 -> quotient=0, remainder=0. Latency is 16 cycles without LC4_DIV_EARLY_EXIT_EN and 1 cycle with it.
- dividend=5, divisor=9 -> quotient=0, remainder=5. Latency is 1 cycle with the macro and 16 without it.
- Hold result_ready=0 for 10 cycles in DONE while toggling start_valid with new operands -> outputs stable, no new accept. Then result_ready=1 -> IDLE; the new operands are accepted the following cycle.
- Assert rst_n=0 asynchronously (between clock edges) at RUN iteration 8 -> all outputs return to reset values immediately. After release, a fresh 200/10 operation -> quotient=20, remainder=0.

Source files
------------

// File: rtl/lc4_div_iter.sv
// Iterative restoring divider for LC4 DIV/MOD: one quotient bit per clock through a shared cla16 subtractor.
// Latency: result_valid on the WIDTH-th edge after accept (1st edge under LC4_DIV_EARLY_EXIT_EN for trivial cases).
// Backpressure: result is held in DONE until result_ready; start_valid is ignored unless start_ready is high.

module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g, p, c;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    gg = '0;
    gp = '0;
    for (int i = 0; i < 4; i++) begin
      gg[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      gp[i] = &p[4*i +: 4];
    end
  end

  // Second-level lookahead across the four nibble groups.
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

  always_comb begin
    c = '0;
    for (int i = 0; i < 4; i++) begin
      c[4*i]   = gc[i];
      c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
      c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & gc[i]);
      c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1]) | (p[4*i+2] & p[4*i+1] & g[4*i])
               | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[4];
endmodule

module lc4_div_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [WIDTH-1:0] rem, quo, dreg;
  logic            dz, early;

  // Shifted partial remainder keeps its carry-out bit so rem >= 2^(WIDTH-1) still divides correctly.
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             nb;
  logic [WIDTH-1:0] quo_nxt, rem_nxt;
  logic             early_acc;

  assign shifted = {rem, quo[WIDTH-1]};

  generate
    if (WIDTH == 16) begin : g_cla
      logic c16;
      cla16 u_cla (
        .a    (shifted[15:0]),
        .b    (~dreg),
        .cin  (1'b1),
        .sum  (diff),
        .cout (c16)
      );
      // Bit 16 of ~{0,dreg} is 1, so the carry out of bit 16 is shifted[16] | c16.
      assign nb = shifted[16] | c16;
    end else begin : g_gen
      logic [WIDTH+1:0] t;
      assign t    = {1'b0, shifted} + {1'b0, ~{1'b0, dreg}} + (WIDTH+2)'(1);
      assign diff = t[WIDTH-1:0];
      assign nb   = t[WIDTH+1];
    end
  endgenerate

  assign quo_nxt = {quo[WIDTH-2:0], nb};
  assign rem_nxt = nb ? diff : shifted[WIDTH-1:0];

`ifdef LC4_DIV_EARLY_EXIT_EN
  assign early_acc = (divisor == '0) || (dividend < divisor);
`else
  assign early_acc = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= '0;
      rem          <= '0;
      quo          <= '0;
      dreg         <= '0;
      dz           <= 1'b0;
      early        <= 1'b0;
      start_ready  <= 1'b1;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid && start_ready) begin
            quo         <= dividend;
            dreg        <= divisor;
            rem         <= '0;
            dz          <= (divisor == '0);
            early       <= early_acc;
            // Early exit parks the counter on its last step so DONE follows on the next edge.
            count       <= early_acc ? LAST : '0;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          rem   <= rem_nxt;
          quo   <= quo_nxt;
          count <= count + 1'b1;
          if (count == LAST) begin
            state        <= DONE;
            busy         <= 1'b0;
            result_valid <= 1'b1;
            if (dz) begin
              quotient  <= '0;
              remainder <= '0;
            end else if (early) begin
              quotient  <= '0;
              remainder <= quo;
            end else begin
              quotient  <= quo_nxt;
              remainder <= rem_nxt;
            end
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            start_ready  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lc4_div_iter.sv
// Directed bench for lc4_div_iter: vector table plus hold-in-DONE and async-reset-abort sequences.
module tb_lc4_div_iter;
  logic        clk = 1'b0;
  logic        rst_n, start_valid, start_ready, result_valid, result_ready, busy;
  logic [15:0] dividend, divisor, quotient, remainder;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic [15:0] dvd;
    logic [15:0] dvs;
    logic [15:0] q;
    logic [15:0] r;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  lc4_div_iter #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .dividend     (dividend),
    .divisor      (divisor),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .quotient     (quotient),
    .remainder    (remainder),
    .busy         (busy)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic int exp_lat(input logic [15:0] dvd, input logic [15:0] dvs);
`ifdef LC4_DIV_EARLY_EXIT_EN
    if (dvs == 16'd0 || dvd < dvs) return 1;
`endif
    return 16;
  endfunction

  // Entered just after the accepting edge; counts edges until result_valid is seen.
  task automatic wait_result(output int lat, output bit ctrl_ok);
    lat = 0;
    ctrl_ok = 1'b1;
    @(negedge clk);
    while (!result_valid && lat < 40) begin
      if (!busy || start_ready) ctrl_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic retire();
    result_ready = 1'b1;
    @(posedge clk);
    #1 result_ready = 1'b0;
    @(negedge clk);
    chk("valid_drop", result_valid, 1'b0);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] q, output logic [15:0] r,
                        output int lat, output bit ctrl_ok);
    @(negedge clk);
    chk("start_ready_idle", start_ready, 1'b1);
    start_valid = 1'b1;
    dividend    = a;
    divisor     = b;
    @(posedge clk);
    #1 start_valid = 1'b0;
    wait_result(lat, ctrl_ok);
    q = quotient;
    r = remainder;
    chk("ready_low_in_done", start_ready, 1'b0);
    retire();
  endtask

  initial begin
    logic [15:0] q, r;
    int          lat;
    bit          ok;

    rst_n        = 1'b0;
    start_valid  = 1'b0;
    result_ready = 1'b0;
    dividend     = '0;
    divisor      = '0;

    vecs[0] = '{16'd100,   16'd7,     16'd14,    16'd2};
    vecs[1] = '{16'hFFFF,  16'd1,     16'hFFFF,  16'd0};
    vecs[2] = '{16'hFFFF,  16'hFFFF,  16'd1,     16'd0};
    vecs[3] = '{16'd1234,  16'd0,     16'd0,     16'd0};
    vecs[4] = '{16'd5,     16'd9,     16'd0,     16'd5};
    vecs[5] = '{16'hFFFF,  16'h8001,  16'd1,     16'h7FFE};
    vecs[6] = '{16'h8000,  16'd3,     16'h2AAA,  16'd2};
    vecs[7] = '{16'd0,     16'd5,     16'd0,     16'd0};
    vecs[8] = '{16'hABCD,  16'h00FF,  16'd172,   16'd121};
    vecs[9] = '{16'd200,   16'd10,    16'd20,    16'd0};

    #12;
    chk("rst_start_ready", start_ready, 1'b1);
    chk("rst_result_valid", result_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_quotient", quotient, 16'd0);
    chk("rst_remainder", remainder, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].dvd, vecs[i].dvs, q, r, lat, ok);
      chk($sformatf("quotient[%0d]", i), q, vecs[i].q);
      chk($sformatf("remainder[%0d]", i), r, vecs[i].r);
      chk($sformatf("latency[%0d]", i), lat, exp_lat(vecs[i].dvd, vecs[i].dvs));
      chk($sformatf("run_ctrl[%0d]", i), ok, 1'b1);
    end

    // Hold the result in DONE while new operands toggle at the start port.
    @(negedge clk);
    start_valid = 1'b1;
    dividend    = 16'd300;
    divisor     = 16'd7;
    @(posedge clk);
    #1 start_valid = 1'b0;
    wait_result(lat, ok);
    chk("hold_reach_done", result_valid, 1'b1);
    dividend = 16'd50;
    divisor  = 16'd5;
    for (int i = 0; i < 10; i++) begin
      start_valid = (i % 2 == 0);
      @(negedge clk);
      chk($sformatf("hold_q[%0d]", i), quotient, 16'd42);
      chk($sformatf("hold_r[%0d]", i), remainder, 16'd6);
      chk($sformatf("hold_vld[%0d]", i), {result_valid, start_ready, busy}, 3'b100);
    end
    start_valid  = 1'b1;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("release_to_idle", {result_valid, start_ready}, 2'b01);
    @(negedge clk);
    chk("accept_after_release", {busy, start_ready}, 2'b10);
    start_valid = 1'b0;
    wait_result(lat, ok);
    chk("hold_next_q", quotient, 16'd10);
    chk("hold_next_r", remainder, 16'd0);
    chk("hold_next_lat", lat + 1, exp_lat(16'd50, 16'd5));
    retire();

    // Asynchronous reset in the middle of RUN aborts the operation.
    @(negedge clk);
    start_valid = 1'b1;
    dividend    = 16'd1000;
    divisor     = 16'd3;
    @(posedge clk);
    #1 start_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outputs", {start_ready, result_valid, busy}, 3'b100);
    chk("abort_quotient", quotient, 16'd0);
    chk("abort_remainder", remainder, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_result", {result_valid, start_ready}, 2'b01);
    run_op(16'd200, 16'd10, q, r, lat, ok);
    chk("post_reset_q", q, 16'd20);
    chk("post_reset_r", r, 16'd0);
    chk("post_reset_lat", lat, exp_lat(16'd200, 16'd10));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
